// File: rtl/prog_sequencer.sv
// prog_sequencer: small accumulator machine with a loadable program memory,
// a data memory and a four-state fetch/execute controller. Every instruction
// costs one FETCH cycle and one EXEC cycle.
//
// Handshake: prog_we is a one-cycle-per-word write strobe honoured only while
// the controller rests in IDLE or HALT. A write takes precedence over run.
// run is a level sampled on the clock edge in IDLE or HALT. portout_valid is
// a single-cycle qualifier for the value now sitting on portout.
module prog_sequencer #(
  parameter int DW  = 4,
  parameter int AW  = 4,
  parameter int DAW = 4
) (
  input  logic          clk,
  input  logic          PC_reset,
  input  logic          prog_we,
  input  logic [3:0]    prog_opc,
  input  logic [DW-1:0] prog_opr,
  input  logic          run,
  input  logic [DW-1:0] portin,
  output logic [DW-1:0] portout,
  output logic          portout_valid,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic          zflag,
  output logic          cflag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_IN   = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   load_ptr_q, load_ptr_d;
  logic [DW-1:0]   y_q, y_d;
  logic [DW-1:0]   y1_q, y1_d;
  logic [DW-1:0]   portout_q, portout_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic            valid_q, valid_d;
  logic [3:0]      ir_opc_q, ir_opc_d;
  logic [DW-1:0]   ir_opr_q, ir_opr_d;

  // Memories are never reset; they keep the program and data across PC_reset.
  logic [DW+3:0]   pm_q [2**AW];
  logic [DW-1:0]   dm_q [2**DAW];

  logic            pm_we;
  logic            dm_we;
  logic [DW:0]     sum_w;
  logic [DW:0]     diff_w;
  logic [AW-1:0]   tgt_w;
  logic [DAW-1:0]  dma_w;
  logic [DW-1:0]   dm_rd_w;

  // The extra top bit of the widened add/subtract is carry-out resp. borrow.
  assign sum_w   = {1'b0, y_q} + {1'b0, y1_q};
  assign diff_w  = {1'b0, y_q} - {1'b0, y1_q};
  assign tgt_w   = ir_opr_q[AW-1:0];
  assign dma_w   = ir_opr_q[DAW-1:0];
  assign dm_rd_w = dm_q[dma_w];

  // Next-state, datapath update and memory write enables.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_ptr_d = load_ptr_q;
    y_d        = y_q;
    y1_d       = y1_q;
    portout_d  = portout_q;
    z_d        = z_q;
    c_d        = c_q;
    valid_d    = 1'b0;
    ir_opc_d   = ir_opc_q;
    ir_opr_d   = ir_opr_q;
    pm_we      = 1'b0;
    dm_we      = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (prog_we) begin
          pm_we      = 1'b1;
          load_ptr_d = load_ptr_q + 1'b1;
        end else if (run) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        {ir_opc_d, ir_opr_d} = pm_q[pc_q];
        state_d              = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
        case (ir_opc_q)
          OP_ADD:  begin y_d = sum_w[DW-1:0];  c_d = sum_w[DW];  end
          OP_SUB:  begin y_d = diff_w[DW-1:0]; c_d = diff_w[DW]; end
          OP_AND:  y_d = y_q & y1_q;
          OP_OR:   y_d = y_q | y1_q;
          OP_LD:   y_d = dm_rd_w;
          OP_ST:   dm_we = 1'b1;
          OP_LDI:  y_d = ir_opr_q;
          OP_OUT:  begin portout_d = y_q; valid_d = 1'b1; end
          OP_MOV:  y1_d = y_q;
          OP_JMP:  pc_d = tgt_w;
          OP_JZ:   if (z_q) pc_d = tgt_w;
          OP_JC:   if (c_q) pc_d = tgt_w;
          OP_IN:   y_d = portin;
          OP_XOR:  y_d = y_q ^ y1_q;
          OP_NOP:  ;
          OP_HALT: begin pc_d = pc_q; state_d = S_HALT; end
          default: ;
        endcase
        // Only instructions that produce a new accumulator value touch zflag.
        case (ir_opc_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_LDI, OP_IN, OP_XOR:
            z_d = (y_d == '0);
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (PC_reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      load_ptr_q <= '0;
      y_q        <= '0;
      y1_q       <= '0;
      portout_q  <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      valid_q    <= 1'b0;
      ir_opc_q   <= '0;
      ir_opr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
      y_q        <= y_d;
      y1_q       <= y1_d;
      portout_q  <= portout_d;
      z_q        <= z_d;
      c_q        <= c_d;
      valid_q    <= valid_d;
      ir_opc_q   <= ir_opc_d;
      ir_opr_q   <= ir_opr_d;
    end
  end

  // Memory writes, suppressed in any cycle where reset is asserted.
  always_ff @(posedge clk) begin
    if (!PC_reset) begin
      if (pm_we) pm_q[load_ptr_q] <= {prog_opc, prog_opr};
      if (dm_we) dm_q[dma_w]      <= y_q;
    end
  end

  assign portout       = portout_q;
  assign portout_valid = valid_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign pc            = pc_q;
  assign zflag         = z_q;
  assign cflag         = c_q;

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DW, 4: data, accumulator and operand width; DW SHALL be >= AW and >= DAW.
REQ-002 Parameter AW, 4: program address width; program memory depth is 2^AW words of {opcode[3:0], operand[DW-1:0]}.
REQ-003 Parameter DAW, 4: data memory address width; data memory depth is 2^DAW words of DW bits.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 PC_reset  in  1  reset, synchronous, active-high.
REQ-006 prog_we  in  1  program-load strobe, one instruction per asserted cycle.
REQ-007 prog_opc  in  4  opcode to load.
REQ-008 prog_opr  in  DW  operand to load.
REQ-009 run  in  1  start execution from address 0.
REQ-010 portin  in  DW  input port, sampled by IN.
REQ-011 portout  out  DW  output port register.
REQ-012 portout_valid  out  1  one-cycle pulse when OUT updates portout.
REQ-013 busy  out  1  high in FETCH or EXEC.
REQ-014 halted  out  1  high in HALT.
REQ-015 pc  out  AW  current program counter.
REQ-016 zflag, cflag  out  1 each  zero and carry flags.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-018 In IDLE or HALT, prog_we SHALL write {prog_opc, prog_opr} to PM[load_ptr] and increment load_ptr, wrapping 2^AW-1 -> 0.
REQ-019 prog_we SHALL be ignored in FETCH/EXEC.
REQ-020 In IDLE or HALT, run with prog_we low SHALL set pc=0 and enter FETCH; if prog_we is also high, the write SHALL occur and run SHALL be ignored.
REQ-021 run SHALL be ignored while busy.
REQ-022 FETCH SHALL latch PM[pc] into the instruction register and go to EXEC; every instruction SHALL take exactly 2 cycles.
REQ-023 EXEC SHALL perform the opcode and set pc=pc+1 (wrapping 2^AW-1 -> 0), unless a branch is taken; it then returns to FETCH, except HALT.
REQ-024 Opcodes 0-3 (Y=accumulator, Y1=operand register, both DW bits):
- 0 ADD: Y<=Y+Y1, cflag<=carry-out.
- 1 SUB: Y<=Y-Y1, cflag<=borrow.
- 2 AND: Y<=Y&Y1.
- 3 OR: Y<=Y|Y1.
REQ-025 Opcodes 4-7 (a=operand[DAW-1:0]):
- 4 LD: Y<=DM[a].
- 5 ST: DM[a]<=Y.
- 6 LDI: Y<=operand.
- 7 OUT: portout<=Y, pulse portout_valid.
REQ-026 Opcodes 8-B (t=operand[AW-1:0]):
- 8 MOV: Y1<=Y.
- 9 JMP: pc<=t.
- A JZ: pc<=t if zflag=1, else pc+1.
- B JC: pc<=t if cflag=1, else pc+1.
REQ-027 Opcodes C-F:
- C IN: Y<=portin.
- D XOR: Y<=Y^Y1.
- E NOP.
- F HALT: enter HALT, pc unchanged.
REQ-028 zflag SHALL be set to (new Y==0) by opcodes 0-4, 6, C, D and SHALL be unchanged otherwise.
REQ-029 cflag SHALL change only on ADD/SUB.
REQ-030 DM reads SHALL be combinational within EXEC; ST then LD to the same address SHALL return the stored value.
REQ-031 JZ/JC SHALL test flag values as they stand at the start of EXEC.
REQ-032 portout_valid SHALL be high only in the cycle after an OUT EXEC edge.
REQ-033 A program with no HALT SHALL run indefinitely with pc wrapping.

Reset
REQ-034 PC_reset SHALL have priority over all inputs in any state, including mid-EXEC; no PM or DM write SHALL occur in that cycle.
REQ-035 Reset values: state=IDLE, pc=0, load_ptr=0, Y=0, Y1=0, zflag=0, cflag=0, portout=0, portout_valid=0, busy=0, halted=0.
REQ-036 PM and DM contents SHALL NOT be cleared by reset.

Verification (DW=AW=DAW=4)
REQ-037 Load LDI 3, MOV, LDI 5, ADD, OUT, HALT; pulse run -> portout=8 with a single valid pulse at the 10th edge after run, halted=1, pc=5.
REQ-038 Program LDI F, MOV, LDI 1, ADD, JZ 6, OUT, LDI 2, OUT, HALT -> after ADD Y=0, zflag=1, cflag=1; the only OUT pulse shows 2.
REQ-039 Program LDI A, ST 3, LDI 0, LD 3, OUT, HALT -> portout=A, zflag=0.
REQ-040 Fill all 16 words with NOP and run -> pc steps 0..F, then 0; halted stays 0 over 40 cycles.
REQ-041 Assert PC_reset during the EXEC of an ST in REQ-039 -> all outputs take reset values and DM[3] is unchanged; rerunning without reload gives portout=A.
REQ-042 prog_we and run asserted while busy are ignored, PM unchanged; prog_we with run in IDLE -> write happens, busy stays 0.
